reg16_serializer: RTL

REG16_SERIALIZER -- requirements
Module: reg16_serializer

---
 rtl/reg16_serializer.sv | 107 ++++++++++
 1 files changed

// File: rtl/reg16_serializer.sv
// reg16_serializer: unloads a parallel word one bit at a time over a valid/ready stream.
// Define SER_PARITY_EN to append an even-parity bit, making each frame WIDTH+1 bits long.
module reg16_serializer #(
  parameter int WIDTH     = 16,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  sreg;
  logic [CW-1:0]     count;
  logic              capture;
  logic              handshake;
`ifdef SER_PARITY_EN
  logic              parity_bit;
`endif

  // The bit under presentation always sits at the exit end of sreg, so a
  // stall simply leaves sreg untouched and out_bit cannot change.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_bit    = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;

    case (state)
      IDLE: begin
        in_ready = !reset;
        capture  = !reset && in_valid;
        if (capture) state_next = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_bit   = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
        handshake = out_ready;
`ifdef SER_PARITY_EN
        if (out_ready && count == LAST_IDX) state_next = PARITY;
`else
        out_last  = (count == LAST_IDX);
        if (out_ready && count == LAST_IDX) state_next = IDLE;
`endif
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_bit   = parity_bit;
        out_last  = 1'b1;
        handshake = out_ready;
        if (out_ready) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Reset wins over capture and handshake; the counter saturates at the last
  // index so it never wraps inside a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      count <= '0;
`ifdef SER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (capture) begin
        sreg  <= in;
        count <= '0;
`ifdef SER_PARITY_EN
        parity_bit <= ^in;
`endif
      end else if (state == SHIFT && handshake) begin
        sreg <= (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
        if (count != LAST_IDX) count <= count + CW'(1);
      end
    end
  end

endmodule
